// File: rtl/muacm_wb_fifo.sv
// muACM Wishbone bridge: CPU DATA/CSR access to a TX byte FIFO (toward host) and an RX byte FIFO (from host).
// Optional interrupt output is built in when MUACM_WB_FIFO_IRQ_EN is defined.
module muacm_wb_fifo #(
    parameter int TX_DEPTH_LOG2 = 5,
    parameter int RX_DEPTH_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wb_addr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    input  logic        rx_valid,
    output logic        rx_ready
`ifdef MUACM_WB_FIFO_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int TX_DEPTH = 2 ** TX_DEPTH_LOG2;
    localparam int RX_DEPTH = 2 ** RX_DEPTH_LOG2;
    localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_INC = (TX_DEPTH_LOG2)'(1);
    localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_INC = (RX_DEPTH_LOG2)'(1);

    logic [8:0]               tx_mem [TX_DEPTH];
    logic [8:0]               rx_mem [RX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] tx_wp, tx_rp;
    logic [RX_DEPTH_LOG2-1:0] rx_wp, rx_rp;
    logic [TX_DEPTH_LOG2:0]   tx_level;
    logic [RX_DEPTH_LOG2:0]   rx_level;
    logic                     tx_full, tx_empty, rx_full, rx_empty;
    logic                     tx_push, tx_pop, tx_flush;
    logic                     rx_push, rx_pop, rx_flush;
    logic                     tx_ovf, rx_pop_pend;
    logic                     bus_rd_start, data_wr, csr_wr;
    logic [1:0]               irq_en_rd;
    logic [31:0]              csr_val, rd_val;
    logic                     unused_bits;

    assign unused_bits = ^{wb_addr[3:2], wb_wdata};

    // Level MSB is set only at exactly 2**N entries.
    assign tx_full  = tx_level[TX_DEPTH_LOG2];
    assign tx_empty = (tx_level == '0);
    assign rx_full  = rx_level[RX_DEPTH_LOG2];
    assign rx_empty = (rx_level == '0);

    assign bus_rd_start = wb_cyc & ~wb_ack & ~wb_we;
    assign data_wr      = wb_ack & wb_we & (wb_addr[1:0] == 2'd0);
    assign csr_wr       = wb_ack & wb_we & (wb_addr[1:0] == 2'd1);

    assign tx_valid = ~tx_empty;
    assign {tx_last, tx_data} = tx_empty ? 9'd0 : tx_mem[tx_rp];
    assign tx_push  = data_wr & ~tx_full;
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_flush = csr_wr & wb_wdata[21];

    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = wb_ack & rx_pop_pend;
    assign rx_flush = csr_wr & wb_wdata[22];

    assign csr_val = {6'b0, irq_en_rd, 3'b0, tx_ovf, rx_empty, rx_full, tx_empty, tx_full,
                      8'(tx_level), 8'(rx_level)};

    always_comb begin
        rd_val = '0;
        case (wb_addr[1:0])
            2'd0:    rd_val = rx_empty ? 32'h8000_0000 : {23'b0, rx_mem[rx_rp]};
            2'd1:    rd_val = csr_val;
            default: rd_val = '0;
        endcase
    end

    // Read data is captured with the ack; the RX pop it implies is deferred to the ack cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack      <= 1'b0;
            wb_rdata    <= '0;
            rx_pop_pend <= 1'b0;
        end else begin
            wb_ack      <= wb_cyc & ~wb_ack;
            wb_rdata    <= bus_rd_start ? rd_val : '0;
            rx_pop_pend <= bus_rd_start & (wb_addr[1:0] == 2'd0) & ~rx_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp] <= wb_wdata[8:0];
        if (rx_push & ~rx_flush)
            rx_mem[rx_wp] <= {rx_last, rx_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_level <= '0;
        end else if (tx_flush) begin
            tx_rp    <= tx_wp;
            tx_level <= '0;
        end else begin
            if (tx_push)
                tx_wp <= tx_wp + TX_PTR_INC;
            if (tx_pop)
                tx_rp <= tx_rp + TX_PTR_INC;
            tx_level <= tx_level + (TX_DEPTH_LOG2 + 1)'(tx_push) - (TX_DEPTH_LOG2 + 1)'(tx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_level <= '0;
        end else if (rx_flush) begin
            rx_rp    <= rx_wp;
            rx_level <= '0;
        end else begin
            if (rx_push)
                rx_wp <= rx_wp + RX_PTR_INC;
            if (rx_pop)
                rx_rp <= rx_rp + RX_PTR_INC;
            rx_level <= rx_level + (RX_DEPTH_LOG2 + 1)'(rx_push) - (RX_DEPTH_LOG2 + 1)'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            tx_ovf <= 1'b0;
        else if (data_wr & tx_full)
            tx_ovf <= 1'b1;
        else if (csr_wr & wb_wdata[20])
            tx_ovf <= 1'b0;
    end

`ifdef MUACM_WB_FIFO_IRQ_EN
    logic [1:0] irq_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 2'b00;
            irq    <= 1'b0;
        end else begin
            if (csr_wr)
                irq_en <= wb_wdata[25:24];
            irq <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty);
        end
    end

    assign irq_en_rd = irq_en;
`else
    assign irq_en_rd = 2'b00;
`endif

endmodule
